// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-ported, 1-cycle-latency word RAM between two requesters
// (port 0: core memory interface, port 1: loader/debug DMA). Grants are
// round-robin, one per cycle, and are decided combinationally. Each granted
// request produces exactly one response one cycle later on the issuing port.
// The block also decodes out-of-range addresses and the LED MMIO register.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   rq_valid_N / rq_addr_N /
//   rq_iswrite_N / rq_data_N         request from port N (N = 0, 1)
//   rq_ready_N                       request on port N accepted this cycle
//   rs_valid_N / rs_data_N           response to port N (no backpressure)
//   ram_addr / ram_write_enable /
//   ram_write / ram_rq_en            RAM request side
//   ram_read                         RAM read data, valid 1 cycle after ram_rq_en
//   led                              LED register
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int unsigned LGSZW    = 8,
  parameter logic [31:0] LED_ADDR = 32'h1001200c
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             rq_valid_0,
  input  logic [31:0]      rq_addr_0,
  input  logic             rq_iswrite_0,
  input  logic [31:0]      rq_data_0,
  output logic             rq_ready_0,
  output logic             rs_valid_0,
  output logic [31:0]      rs_data_0,

  input  logic             rq_valid_1,
  input  logic [31:0]      rq_addr_1,
  input  logic             rq_iswrite_1,
  input  logic [31:0]      rq_data_1,
  output logic             rq_ready_1,
  output logic             rs_valid_1,
  output logic [31:0]      rs_data_1,

  output logic [LGSZW+1:0] ram_addr,
  output logic             ram_write_enable,
  output logic [31:0]      ram_write,
  output logic             ram_rq_en,
  input  logic [31:0]      ram_read,

  output logic [7:0]       led
);

  // Port that received the most recent grant; the other port wins a conflict.
  logic        r_last_grant;
  // Response pipeline: one stage, matching the RAM read latency.
  logic        r_inflight;
  logic        r_owner;
  logic        r_is_read_inrange;
  logic [7:0]  r_led;

  logic        w_gnt_0;
  logic        w_gnt_1;
  logic        w_gnt;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        w_iswrite;
  logic        w_in_range;
  logic        w_is_led;
  logic [31:0] w_rs_data;

  // No grants while reset is held.
  assign w_gnt_0 = !reset && rq_valid_0 && (!rq_valid_1 || r_last_grant);
  assign w_gnt_1 = !reset && rq_valid_1 && (!rq_valid_0 || !r_last_grant);
  assign w_gnt   = w_gnt_0 | w_gnt_1;

  assign rq_ready_0 = w_gnt_0;
  assign rq_ready_1 = w_gnt_1;

  // Granted request fields; all zero when nothing is granted.
  always_comb begin
    w_addr    = 32'h0;
    w_data    = 32'h0;
    w_iswrite = 1'b0;
    if (w_gnt_0) begin
      w_addr    = rq_addr_0;
      w_data    = rq_data_0;
      w_iswrite = rq_iswrite_0;
    end else if (w_gnt_1) begin
      w_addr    = rq_addr_1;
      w_data    = rq_data_1;
      w_iswrite = rq_iswrite_1;
    end
  end

  // Any address bit above the RAM span marks the access out of range; no wrap.
  assign w_in_range = ((w_addr >> (LGSZW + 2)) == 32'h0);
  assign w_is_led   = w_gnt && w_iswrite && (w_addr == LED_ADDR);

  assign ram_rq_en        = w_gnt;
  assign ram_addr         = w_addr[LGSZW+1:0];
  assign ram_write        = w_data;
  assign ram_write_enable = w_gnt && w_iswrite && w_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant      <= 1'b1;
      r_inflight        <= 1'b0;
      r_owner           <= 1'b0;
      r_is_read_inrange <= 1'b0;
      r_led             <= 8'hff;
    end else begin
      r_inflight        <= w_gnt;
      r_is_read_inrange <= w_gnt && !w_iswrite && w_in_range;
      if (w_gnt) begin
        r_last_grant <= w_gnt_1;
        r_owner      <= w_gnt_1;
      end
      if (w_is_led) begin
        r_led <= w_data[23:16];
      end
    end
  end

  // Writes and out-of-range reads answer with zero data.
  assign w_rs_data = r_is_read_inrange ? ram_read : 32'h0;

  assign rs_valid_0 = r_inflight && !r_owner;
  assign rs_valid_1 = r_inflight && r_owner;
  assign rs_data_0  = rs_valid_0 ? w_rs_data : 32'h0;
  assign rs_data_1  = rs_valid_1 ? w_rs_data : 32'h0;

  assign led = r_led;

endmodule
